membus_master: RTL
==================

Name: membus_master

Overview:
- Avalon-MM style master that runs PDP-6 memory cycles (read, write, read-modify-write) from the processor side onto the 18-bit-address / 36-bit-data memory interface.
- It is the initiator counterpart of the fast-memory and core-memory responders.
- Sits between the processor's memory-cycle control and the memory bus, and converts a level request/pulse handshake into address/read/write/waitrequest transactions.
- Flags non-existent memory when a responder never releases waitrequest.

Parameters:
- TIMEOUT, 1024: waitrequest cycles tolerated before abort with NXM; 0 disables timeout.
- CNT_W, 11: timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_req  in  1  processor cycle request, level; held until cycle finishes
- i_rd  in  1  cycle includes read phase; sampled with i_req rise
- i_wr  in  1  cycle includes write phase; sampled with i_req rise
- i_addr  in  18  memory address; sampled with i_req rise
- i_wdata  in  36  write data; sampled at start (write-only) or at i_wr_rs (RMW)
- i_wr_rs  in  1  RMW write restart pulse from processor
- o_addr_ack  out  1  one-cycle pulse: request accepted, address latched
- o_rd_rs  out  1  one-cycle pulse: o_rdata valid
- o_rdata  out  36  read data, held until the next read completes
- o_done  out  1  one-cycle pulse: cycle finished, normally or by NXM
- o_nxm  out  1  one-cycle pulse coincident with o_done on timeout
- o_address  out  18  bus address
- o_read  out  1  bus read command
- o_write  out  1  bus write command
- o_writedata  out  36  bus write data
- i_readdata  in  36  bus read data, valid when o_read=1 and i_waitrequest=0
- i_waitrequest  in  1  responder stall

Behaviour:
- Reset is asynchronous, active-low on i_reset_n; clock is i_clk. All outputs and registers reset to 0; state resets to IDLE.
- Reset asserted mid-cycle drops o_read/o_write immediately, and no o_done is issued.
- States:
  - IDLE: on i_req=1 with i_rd|i_wr:
    - latch i_addr into o_address and the rd/wr flags;
    - latch i_wdata if write-only;
    - pulse o_addr_ack next cycle;
    - go RD if i_rd, else WR.
  - IDLE with i_req=1 and neither flag set: go DONE, pulse o_done, no bus activity.
  - RD: o_read=1.
    - Edge with i_waitrequest=0: capture i_readdata into o_rdata; drop o_read; pulse o_rd_rs next cycle.
    - Then go WAIT_WR if the wr flag is set, else DONE with o_done pulse.
  - WAIT_WR: bus idle. On i_wr_rs=1: latch i_wdata into o_writedata, go WR. No timeout in this state.
  - WR: o_write=1. Edge with i_waitrequest=0: drop o_write, go DONE with o_done pulse.
  - DONE: wait for i_req=0, then IDLE. A cycle is never restarted while i_req stays high.
- Command hold: o_address, o_writedata, o_read and o_write are stable while i_waitrequest=1. o_read and o_write are never both 1.
- Latency with zero waitrequest:
  - read: o_addr_ack in cycle 1, o_read in cycle 1, o_rd_rs/o_done in cycle 2;
  - write: o_write in cycle 1, o_done in cycle 2.
  - Each waitrequest cycle adds one.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle with i_waitrequest=1.
  - When the count reaches TIMEOUT (TIMEOUT≠0): drop the command, pulse o_nxm and o_done, go DONE.
  - On timeout in RD, o_rdata keeps its old value and o_rd_rs is not pulsed. A timeout in RD of an RMW cycle skips the write phase.
- i_wr_rs outside WAIT_WR is ignored. Address, flag and data inputs are ignored except at their sampling points.

Decomposition:
- Shared package:
  - ADDR_W=18, DATA_W=36;
  - state enum {IDLE, RD, WAIT_WR, WR, DONE};
  - cycle-type encoding shared with the memory responders.
- No sub-module: the timeout counter is inline. The block stays a single FSM, about 150–200 lines.

Test Plan:
- Read, zero wait: i_req with rd=1, addr=0o000017; responder returns 0o123456654321 -> o_read for 1 cycle, o_rd_rs in cycle 2, o_rdata=0o123456654321, o_done once.
- Write, 3 waitrequest cycles: wr=1, addr=0o000005, wdata=0o777000000777 -> o_write held 4 cycles with stable address/data; memory word 5 = 0o777000000777; o_done in cycle 5.
- RMW: rd=wr=1 at addr 3 holding 0o1; processor pulses i_wr_rs with 0o2 ten cycles after o_rd_rs -> bus idle for those ten cycles, then one write of 0o2, then o_done; o_rdata=0o1.
- NXM: TIMEOUT=8, i_waitrequest stuck 1 on a read -> o_read dropped after 8 cycles, o_nxm=o_done=1 for one cycle, no o_rd_rs.
- Handshake: i_req held high for 20 cycles after o_done -> exactly one bus transaction. Then i_req low for 1 cycle and high again -> a second transaction.
- Reset mid-cycle: assert i_reset_n=0 while in WR with waitrequest=1 -> o_write=0 immediately, all outputs 0, state IDLE after release.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-6 memory bus: widths, master FSM states and
// the cycle-type encoding also used by the memory responders.
package membus_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 36;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WAIT_WR = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Bit 0 = read phase, bit 1 = write phase.
    typedef enum logic [1:0] {
        CYC_NONE = 2'b00,
        CYC_RD   = 2'b01,
        CYC_WR   = 2'b10,
        CYC_RMW  = 2'b11
    } cyc_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
    } bus_cmd_t;

    function automatic cyc_t cyc_decode(input logic rd, input logic wr);
        return cyc_t'({wr, rd});
    endfunction

endpackage

// File: rtl/membus_master.sv
// Memory-cycle initiator: turns the processor's level request / pulse handshake
// into address/read/write/waitrequest bus transactions, with NXM timeout.
module membus_master
    import membus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_wr_rs,
    output logic              o_addr_ack,
    output logic              o_rd_rs,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_nxm,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_read,
    output logic              o_write,
    output logic [DATA_W-1:0] o_writedata,
    input  logic [DATA_W-1:0] i_readdata,
    input  logic              i_waitrequest
);

    // Abort fires on the stalled edge that would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    cyc_t              cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              addr_ack_q, addr_ack_d;
    logic              rd_rs_q, rd_rs_d;
    logic              done_q, done_d;
    logic              nxm_q, nxm_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            cyc_q      <= CYC_NONE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            rdata_q    <= '0;
            addr_ack_q <= 1'b0;
            rd_rs_q    <= 1'b0;
            done_q     <= 1'b0;
            nxm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            addr_ack_q <= addr_ack_d;
            rd_rs_q    <= rd_rs_d;
            done_q     <= done_d;
            nxm_q      <= nxm_d;
        end
    end

    // Next state; read/write commands default low and are re-asserted while stalled.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        cmd_d.read    = 1'b0;
        cmd_d.write   = 1'b0;
        rdata_d       = rdata_q;
        addr_ack_d    = 1'b0;
        rd_rs_d       = 1'b0;
        done_d        = 1'b0;
        nxm_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (i_rd || i_wr) begin
                        cyc_d         = cyc_decode(i_rd, i_wr);
                        cmd_d.address = i_addr;
                        addr_ack_d    = 1'b1;
                        cnt_d         = '0;
                        if (i_rd) begin
                            state_d    = RD;
                            cmd_d.read = 1'b1;
                        end else begin
                            state_d         = WR;
                            cmd_d.write     = 1'b1;
                            cmd_d.writedata = i_wdata;
                        end
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            RD: begin
                if (!i_waitrequest) begin
                    rdata_d = i_readdata;
                    rd_rs_d = 1'b1;
                    if (cyc_q == CYC_RMW) begin
                        state_d = WAIT_WR;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    nxm_d   = 1'b1;
                end else begin
                    cmd_d.read = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end

            WAIT_WR: begin
                if (i_wr_rs) begin
                    state_d         = WR;
                    cmd_d.write     = 1'b1;
                    cmd_d.writedata = i_wdata;
                    cnt_d           = '0;
                end
            end

            WR: begin
                if (!i_waitrequest) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    nxm_d   = 1'b1;
                end else begin
                    cmd_d.write = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (!i_req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_addr_ack  = addr_ack_q;
    assign o_rd_rs     = rd_rs_q;
    assign o_rdata     = rdata_q;
    assign o_done      = done_q;
    assign o_nxm       = nxm_q;
    assign o_address   = cmd_q.address;
    assign o_read      = cmd_q.read;
    assign o_write     = cmd_q.write;
    assign o_writedata = cmd_q.writedata;

endmodule
